// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Holds the decoded instruction for one cycle and presents forwarded ALU
// operands, store data and registered control to the execute stage.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_ALUCode,
  input  logic        id_srcA,
  input  logic        id_srcB,
  input  logic [2:0]  id_ctrl,
  input  logic        exmem_wen,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_wen,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  ALUCode,
  output logic [31:0] store_data,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_ctrl,
  output logic        load_use_stall
);

  // ctrl bit order: {reg_write, mem_read, mem_write}
  localparam int unsigned CtrlMemRead = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_code;
    logic        src_a;
    logic        src_b;
    logic [2:0]  ctrl;
  } idex_t;

  idex_t idex_q;
  idex_t idex_d;

  logic [31:0] fwd1;
  logic [31:0] fwd2;

  // Picks the newest in-flight value for a source register; x0 is never forwarded.
  function automatic logic [31:0] forward_sel(
    input logic [4:0]  rs,
    input logic [31:0] reg_data,
    input logic        em_wen,
    input logic [4:0]  em_rd,
    input logic [31:0] em_result,
    input logic        mw_wen,
    input logic [4:0]  mw_rd,
    input logic [31:0] mw_result
  );
    if (em_wen && (em_rd != 5'd0) && (em_rd == rs)) begin
      return em_result;
    end else if (mw_wen && (mw_rd != 5'd0) && (mw_rd == rs)) begin
      return mw_result;
    end
    return reg_data;
  endfunction

  // Load in EX whose destination is read by the instruction now in decode.
  // Decode indices are compared raw, so an unused rs field can still trigger it.
  assign load_use_stall = idex_q.ctrl[CtrlMemRead]
                        && (idex_q.rd != 5'd0)
                        && ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));

  // Next-state selection: flush > stall > load-use bubble > normal load.
  always_comb begin
    // NOTE: default assignment first so every path assigns idex_d and no latch is inferred.
    idex_d = idex_q;
    if (flush) begin
      idex_d = '0;
    end else if (stall) begin
      idex_d = idex_q;
    end else if (load_use_stall) begin
      idex_d = '0;
    end else begin
      idex_d.pc       = id_pc;
      idex_d.rs1_data = id_rs1_data;
      idex_d.rs2_data = id_rs2_data;
      idex_d.imm      = id_imm;
      idex_d.rs1      = id_rs1;
      idex_d.rs2      = id_rs2;
      idex_d.rd       = id_rd;
      idex_d.alu_code = id_ALUCode;
      idex_d.src_a    = id_srcA;
      idex_d.src_b    = id_srcB;
      idex_d.ctrl     = id_ctrl;
    end
  end

  // Pipeline register with synchronous reset that overrides flush and stall.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps register updates order-independent across always_ff blocks.
    if (!rst_n) begin
      // NOTE: data fields are cleared too, so a reset during a stall leaves a clean bubble with A/B/store_data at 0.
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  // Forwarding muxes and operand selection, zero-cycle from registered state.
  always_comb begin
    fwd1 = forward_sel(idex_q.rs1, idex_q.rs1_data, exmem_wen, exmem_rd, exmem_result,
                       memwb_wen, memwb_rd, memwb_result);
    fwd2 = forward_sel(idex_q.rs2, idex_q.rs2_data, exmem_wen, exmem_rd, exmem_result,
                       memwb_wen, memwb_rd, memwb_result);
    A          = idex_q.src_a ? idex_q.pc  : fwd1;
    B          = idex_q.src_b ? idex_q.imm : fwd2;
    store_data = fwd2;
  end

  assign ALUCode = idex_q.alu_code;
  assign ex_rd   = idex_q.rd;
  assign ex_ctrl = idex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of expected EX outputs per
// loaded instruction plus inline checks of forwarding, hazard and hold behaviour.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_ALUCode;
  logic        id_srcA, id_srcB;
  logic [2:0]  id_ctrl;
  logic        exmem_wen, memwb_wen;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] A, B, store_data;
  logic [3:0]  ALUCode;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_ctrl;
  logic        load_use_stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [2:0]  ctrl;
  } exp_t;

  exp_t exp_q[$];

  id_ex_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .id_pc          (id_pc),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .id_imm         (id_imm),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_ALUCode     (id_ALUCode),
    .id_srcA        (id_srcA),
    .id_srcB        (id_srcB),
    .id_ctrl        (id_ctrl),
    .exmem_wen      (exmem_wen),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_wen      (memwb_wen),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .A              (A),
    .B              (B),
    .ALUCode        (ALUCode),
    .store_data     (store_data),
    .ex_rd          (ex_rd),
    .ex_ctrl        (ex_ctrl),
    .load_use_stall (load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge so outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_fwd();
    exmem_wen = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_wen = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  // Drive a decode instruction and push what EX must show once it is loaded
  // (forwarding sources idle at compare time).
  task automatic drive_and_expect(
    input logic [31:0] pc, input logic [31:0] rs1d, input logic [31:0] rs2d,
    input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic [3:0] alu, input logic sa, input logic sb,
    input logic [2:0] ctrl
  );
    exp_t e;
    id_pc = pc; id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ALUCode = alu;
    id_srcA = sa; id_srcB = sb; id_ctrl = ctrl;
    e.a = sa ? pc : rs1d;
    e.b = sb ? imm : rs2d;
    e.sd = rs2d;
    e.alu = alu;
    e.rd = rd;
    e.ctrl = ctrl;
    exp_q.push_back(e);
  endtask

  task automatic expect_bubble();
    exp_t e;
    e.a = 32'd0; e.b = 32'd0; e.sd = 32'd0;
    e.alu = 4'd0; e.rd = 5'd0; e.ctrl = 3'b000;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the current EX outputs.
  task automatic sb_compare(input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, nothing expected", name);
      return;
    end
    e = exp_q.pop_front();
    if ({A, B, store_data, ALUCode, ex_rd, ex_ctrl} !==
        {e.a, e.b, e.sd, e.alu, e.rd, e.ctrl}) begin
      errors++;
      $display("FAIL %s: got A=%h B=%h sd=%h alu=%0d rd=%0d ctrl=%b expected A=%h B=%h sd=%h alu=%0d rd=%0d ctrl=%b",
               name, A, B, store_data, ALUCode, ex_rd, ex_ctrl,
               e.a, e.b, e.sd, e.alu, e.rd, e.ctrl);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    // Forwarding sources target x0; they must not leak into A/B.
    exmem_wen = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hDEAD_BEEF;
    memwb_wen = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hCAFE_F00D;
    id_pc = 32'h1234; id_rs1_data = 32'h55; id_rs2_data = 32'h66; id_imm = 32'h77;
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3; id_ALUCode = 4'd5;
    id_srcA = 1'b0; id_srcB = 1'b0; id_ctrl = 3'b110;
    tick();
    tick();
    expect_bubble();
    sb_compare("reset_state");
    checks++;
    if (load_use_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_lus: got %b expected 0", load_use_stall);
    end
    idle_fwd();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive_and_expect(32'h40, 32'd5, 32'd9, 32'd7, 5'd3, 5'd8, 5'd1, 4'd0, 1'b0, 1'b1, 3'b100);
    tick();
    sb_compare("basic_imm");
    drive_and_expect(32'h44, 32'h10, 32'h20, 32'h30, 5'd4, 5'd5, 5'd6, 4'd9, 1'b1, 1'b0, 3'b001);
    tick();
    sb_compare("pc_and_rs2");
    drive_and_expect(32'h48, 32'h11, 32'h22, 32'h33, 5'd7, 5'd9, 5'd10, 4'd10, 1'b1, 1'b1, 3'b101);
    tick();
    sb_compare("pc_imm_store_rs2");
  endtask

  task automatic test_forwarding();
    drive_and_expect(32'h80, 32'h11, 32'h22, 32'h99, 5'd4, 5'd4, 5'd2, 4'd3, 1'b0, 1'b0, 3'b100);
    tick();
    sb_compare("fwd_load");
    stall = 1'b1;
    exmem_wen = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hAA;
    memwb_wen = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hBB;
    #1;
    checks++;
    if ({A, B, store_data} !== {32'hAA, 32'hAA, 32'hAA}) begin
      errors++;
      $display("FAIL fwd_exmem_priority: got A=%h B=%h sd=%h expected all 000000aa", A, B, store_data);
    end
    exmem_wen = 1'b0;
    #1;
    checks++;
    if ({A, B, store_data} !== {32'hBB, 32'hBB, 32'hBB}) begin
      errors++;
      $display("FAIL fwd_memwb: got A=%h B=%h sd=%h expected all 000000bb", A, B, store_data);
    end
    memwb_rd = 5'd5;
    #1;
    checks++;
    if ({A, B, store_data} !== {32'h11, 32'h22, 32'h22}) begin
      errors++;
      $display("FAIL fwd_none: got A=%h B=%h sd=%h expected 11/22/22", A, B, store_data);
    end
    exmem_wen = 1'b1; exmem_rd = 5'd7;
    #1;
    checks++;
    if (A !== 32'h11) begin
      errors++;
      $display("FAIL fwd_rd_mismatch: got A=%h expected 00000011", A);
    end
    idle_fwd();
    stall = 1'b0;
  endtask

  task automatic test_x0();
    drive_and_expect(32'h100, 32'h33, 32'd0, 32'h44, 5'd0, 5'd0, 5'd3, 4'd1, 1'b0, 1'b0, 3'b100);
    tick();
    sb_compare("x0_load");
    stall = 1'b1;
    exmem_wen = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFF;
    memwb_wen = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hEE;
    #1;
    checks++;
    if ({A, B, store_data} !== {32'h33, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL x0_no_forward: got A=%h B=%h sd=%h expected 33/0/0", A, B, store_data);
    end
    idle_fwd();
    stall = 1'b0;
  endtask

  task automatic test_load_use();
    drive_and_expect(32'h200, 32'd1, 32'd2, 32'd3, 5'd1, 5'd2, 5'd6, 4'd0, 1'b0, 1'b1, 3'b010);
    tick();
    sb_compare("lu_load_in_ex");
    // Dependent instruction reads x6 through rs2.
    id_rs1 = 5'd1; id_rs2 = 5'd6; id_rd = 5'd7; id_ctrl = 3'b100; id_ALUCode = 4'd5;
    #1;
    checks++;
    if (load_use_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_detect_rs2: got %b expected 1", load_use_stall);
    end
    expect_bubble();
    tick();
    sb_compare("lu_bubble");
    checks++;
    if (load_use_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_clear_after_bubble: got %b expected 0", load_use_stall);
    end
    // The dependent instruction, still in decode, now loads normally.
    drive_and_expect(32'h204, 32'h70, 32'h80, 32'h90, 5'd1, 5'd6, 5'd7, 4'd5, 1'b0, 1'b0, 3'b100);
    tick();
    sb_compare("lu_dependent_loads");
    // Hazard on rs1 while stalled: request asserted, register holds.
    drive_and_expect(32'h208, 32'd0, 32'd0, 32'd4, 5'd0, 5'd0, 5'd6, 4'd0, 1'b0, 1'b1, 3'b010);
    tick();
    sb_compare("lu_second_load");
    id_rs1 = 5'd6; id_rs2 = 5'd0; id_ctrl = 3'b100; id_rd = 5'd9;
    stall = 1'b1;
    #1;
    checks++;
    if (load_use_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_detect_rs1: got %b expected 1", load_use_stall);
    end
    tick();
    checks++;
    if ({ex_ctrl, ex_rd} !== {3'b010, 5'd6}) begin
      errors++;
      $display("FAIL lu_stall_wins: got ctrl=%b rd=%0d expected 010/6", ex_ctrl, ex_rd);
    end
    stall = 1'b0;
    // Load targeting x0 never raises a hazard.
    drive_and_expect(32'h20C, 32'd0, 32'd0, 32'd8, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1, 3'b010);
    tick();
    sb_compare("lu_load_x0");
    checks++;
    if (load_use_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_x0_no_hazard: got %b expected 0", load_use_stall);
    end
  endtask

  task automatic test_stall_flush();
    drive_and_expect(32'h300, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd9, 4'd4, 1'b0, 1'b0, 3'b100);
    tick();
    sb_compare("sf_load");
    stall = 1'b1; flush = 1'b1;
    id_ALUCode = 4'd6; id_rd = 5'd15; id_ctrl = 3'b100;
    expect_bubble();
    tick();
    sb_compare("sf_flush_over_stall");
    stall = 1'b0; flush = 1'b0;
    drive_and_expect(32'h304, 32'h5, 32'h6, 32'h7, 5'd3, 5'd4, 5'd10, 4'd7, 1'b0, 1'b0, 3'b101);
    tick();
    sb_compare("sf_load2");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_ALUCode = 4'(i + 1); id_rd = 5'(20 + i); id_ctrl = 3'b110;
      tick();
      checks++;
      if ({ALUCode, ex_rd, ex_ctrl} !== {4'd7, 5'd10, 3'b101}) begin
        errors++;
        $display("FAIL sf_hold_cycle%0d: got alu=%0d rd=%0d ctrl=%b expected 7/10/101",
                 i, ALUCode, ex_rd, ex_ctrl);
      end
    end
    stall = 1'b0; flush = 1'b1;
    expect_bubble();
    tick();
    sb_compare("sf_flush_alone");
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    drive_and_expect(32'h400, 32'hA, 32'hB, 32'hC, 5'd1, 5'd2, 5'd12, 4'd8, 1'b1, 1'b1, 3'b110);
    tick();
    sb_compare("rms_load");
    stall = 1'b1;
    tick();
    checks++;
    if ({ALUCode, ex_rd, ex_ctrl} !== {4'd8, 5'd12, 3'b110}) begin
      errors++;
      $display("FAIL rms_held: got alu=%0d rd=%0d ctrl=%b expected 8/12/110", ALUCode, ex_rd, ex_ctrl);
    end
    rst_n = 1'b0;
    expect_bubble();
    tick();
    sb_compare("rms_reset_clears");
    rst_n = 1'b1; stall = 1'b0;
    drive_and_expect(32'h404, 32'hD, 32'hE, 32'hF, 5'd3, 5'd4, 5'd13, 4'd9, 1'b0, 1'b0, 3'b100);
    tick();
    sb_compare("rms_after_release");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      drive_and_expect($urandom, $urandom, $urandom, $urandom,
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), 4'($urandom_range(0, 10)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)) & 3'b101);
      tick();
      sb_compare("back_to_back");
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    stall = 1'b0; flush = 1'b0; rst_n = 1'b0;
    idle_fwd();
    test_reset();
    test_basic();
    test_forwarding();
    test_x0();
    test_load_use();
    test_stall_flush();
    test_reset_mid_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
